// File: rtl/piso_serial_tx.sv
// rtl/piso_serial_tx.sv - framed parallel-in serial-out transmitter (start, data, stop)
module piso_serial_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             Sout,
  output logic             busy,
  output logic             done
);

  // One spare bit on each counter so the terminal compare never aliases a wrapped value.
  localparam int SCW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BCW = $clog2(WIDTH) + 1;
  localparam logic [SCW-1:0] SUB_LAST = SCW'(CLKS_PER_BIT - 1);
  localparam logic [SCW-1:0] SUB_ONE  = SCW'(1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
  localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [SCW-1:0]   sub_cnt_q, sub_cnt_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;

  logic             bit_end;
  logic             next_bit;
  logic [WIDTH-1:0] shreg_shifted;

  // bit_end marks the last clock of the current bit period.
  assign bit_end       = (sub_cnt_q == SUB_LAST);
  assign next_bit      = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign shreg_shifted = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

  // State register with synchronous reset; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: each non-idle state lasts whole bit periods.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (din_valid) state_d = S_START;
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA:  if (bit_end && (bit_cnt_q == BIT_LAST)) state_d = S_STOP;
      S_STOP:  if (bit_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    din_ready = 1'b0;
    busy      = 1'b0;
    if (state_q == S_IDLE) begin
      din_ready = 1'b1;
    end else begin
      busy = 1'b1;
    end
  end

  // Datapath next values: the line bit is registered one period ahead of its bit slot.
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    sub_cnt_d = bit_end ? '0 : (sub_cnt_q + SUB_ONE);
    sout_d    = sout_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        sub_cnt_d = '0;
        bit_cnt_d = '0;
        sout_d    = 1'b1;
        if (din_valid) begin
          shreg_d = din;
          sout_d  = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          sout_d  = next_bit;
          shreg_d = shreg_shifted;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == BIT_LAST) begin
            sout_d    = 1'b1;
            bit_cnt_d = '0;
          end else begin
            sout_d    = next_bit;
            shreg_d   = shreg_shifted;
            bit_cnt_d = bit_cnt_q + BIT_ONE;
          end
        end
      end
      S_STOP: begin
        if (bit_end) done_d = 1'b1;
      end
      default: begin
        sout_d = 1'b1;
      end
    endcase
  end

  // Datapath registers; reset returns the line to idle-high and clears the word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      sub_cnt_q <= '0;
      sout_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      sub_cnt_q <= sub_cnt_d;
      sout_q    <= sout_d;
      done_q    <= done_d;
    end
  end

  assign Sout = sout_q;
  assign done = done_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// tb/tb_piso_serial_tx.sv - directed self-checking bench for piso_serial_tx
module tb_piso_serial_tx;

  logic clk;
  logic rst_n;

  logic [7:0] a_din, b_din, c_din;
  logic       a_valid, b_valid, c_valid;
  logic       a_ready, b_ready, c_ready;
  logic       a_sout, b_sout, c_sout;
  logic       a_busy, b_busy, c_busy;
  logic       a_done, b_done, c_done;

  int checks = 0;
  int errors = 0;

  piso_serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .din(a_din), .din_valid(a_valid),
    .din_ready(a_ready), .Sout(a_sout), .busy(a_busy), .done(a_done)
  );

  piso_serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .din(b_din), .din_valid(b_valid),
    .din_ready(b_ready), .Sout(b_sout), .busy(b_busy), .done(b_done)
  );

  piso_serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .din(c_din), .din_valid(c_valid),
    .din_ready(c_ready), .Sout(c_sout), .busy(c_busy), .done(c_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the falling edge right after the accept edge of u_a; exp[9] is the start bit.
  // Returns at the falling edge where done must be high.
  task automatic frame_a(input string tag, input logic [9:0] exp);
    for (int j = 0; j < 10; j++) begin
      chk($sformatf("%s_sout%0d", tag, j), {31'd0, a_sout}, {31'd0, exp[9-j]});
      chk($sformatf("%s_busy%0d", tag, j), {31'd0, a_busy}, 32'd1);
      chk($sformatf("%s_rdy%0d", tag, j), {31'd0, a_ready}, 32'd0);
      chk($sformatf("%s_done%0d", tag, j), {31'd0, a_done}, 32'd0);
      @(negedge clk);
    end
    chk($sformatf("%s_done", tag), {31'd0, a_done}, 32'd1);
    chk($sformatf("%s_idle_sout", tag), {31'd0, a_sout}, 32'd1);
    chk($sformatf("%s_idle_rdy", tag), {31'd0, a_ready}, 32'd1);
    chk($sformatf("%s_idle_busy", tag), {31'd0, a_busy}, 32'd0);
  endtask

  initial begin
    int           busy_cnt;
    logic [9:0]   exp_c;
    rst_n   = 1'b0;
    a_din   = 8'h00; b_din = 8'h00; c_din = 8'h00;
    a_valid = 1'b0;  b_valid = 1'b0; c_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state on all three instances
    chk("rst_a_sout", {31'd0, a_sout}, 32'd1);
    chk("rst_a_rdy",  {31'd0, a_ready}, 32'd1);
    chk("rst_a_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_a_done", {31'd0, a_done}, 32'd0);
    chk("rst_b_sout", {31'd0, b_sout}, 32'd1);
    chk("rst_b_rdy",  {31'd0, b_ready}, 32'd1);
    chk("rst_b_busy", {31'd0, b_busy}, 32'd0);
    chk("rst_b_done", {31'd0, b_done}, 32'd0);
    chk("rst_c_sout", {31'd0, c_sout}, 32'd1);
    chk("rst_c_rdy",  {31'd0, c_ready}, 32'd1);
    chk("rst_c_busy", {31'd0, c_busy}, 32'd0);
    chk("rst_c_done", {31'd0, c_done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: A5 MSB first, din changed right after acceptance
    a_din = 8'hA5; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0; a_din = 8'h00;
    frame_a("t1", 10'b0101001011);
    @(negedge clk);
    chk("t1_done_clr", {31'd0, a_done}, 32'd0);
    chk("t1_after_sout", {31'd0, a_sout}, 32'd1);

    // T2: 01 LSB first, busy for exactly 10 clocks
    b_din = 8'h01; b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    busy_cnt = 0;
    for (int j = 0; j < 10; j++) begin
      logic [9:0] exp_b;
      exp_b = 10'b0100000001;
      chk($sformatf("t2_sout%0d", j), {31'd0, b_sout}, {31'd0, exp_b[9-j]});
      if (b_busy) busy_cnt++;
      @(negedge clk);
    end
    chk("t2_done", {31'd0, b_done}, 32'd1);
    for (int j = 0; j < 3; j++) begin
      if (b_busy) busy_cnt++;
      @(negedge clk);
    end
    chk("t2_busy_cnt", busy_cnt, 32'd10);

    // T3: F0 with four clocks per bit, done 40 clocks after accept
    c_din = 8'hF0; c_valid = 1'b1;
    @(negedge clk);
    c_valid = 1'b0;
    exp_c = 10'b0111100001;
    for (int j = 0; j < 40; j++) begin
      chk($sformatf("t3_sout%0d", j), {31'd0, c_sout}, {31'd0, exp_c[9-(j/4)]});
      chk($sformatf("t3_done%0d", j), {31'd0, c_done}, 32'd0);
      @(negedge clk);
    end
    chk("t3_done", {31'd0, c_done}, 32'd1);
    chk("t3_idle_sout", {31'd0, c_sout}, 32'd1);
    @(negedge clk);
    chk("t3_done_clr", {31'd0, c_done}, 32'd0);

    // T4: valid held high; FF frame intact, 00 starts 11 clocks after the first accept
    a_din = 8'hFF; a_valid = 1'b1;
    @(negedge clk);
    a_din = 8'h00;
    frame_a("t4a", 10'b0111111111);
    @(negedge clk);
    a_valid = 1'b0;
    frame_a("t4b", 10'b0000000001);
    @(negedge clk);
    chk("t4_done_clr", {31'd0, a_done}, 32'd0);

    // T5: reset during data bit 3 aborts the frame without done
    a_din = 8'hA5; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_bit3", {31'd0, a_sout}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5_rst_sout", {31'd0, a_sout}, 32'd1);
    chk("t5_rst_busy", {31'd0, a_busy}, 32'd0);
    chk("t5_rst_rdy",  {31'd0, a_ready}, 32'd1);
    chk("t5_rst_done", {31'd0, a_done}, 32'd0);
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      chk($sformatf("t5_nodone%0d", j), {31'd0, a_done}, 32'd0);
      chk($sformatf("t5_idle%0d", j), {31'd0, a_sout}, 32'd1);
    end
    a_din = 8'h3C; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    frame_a("t5", 10'b0001111001);
    @(negedge clk);
    chk("t5_done_clr", {31'd0, a_done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
